// File: rtl/reg_pkg.sv
// Shared definitions for the register bank: FunSel operation encodings.
package reg_pkg;

    localparam logic [2:0] FS_DEC    = 3'b000;  // Q - 1
    localparam logic [2:0] FS_INC    = 3'b001;  // Q + 1
    localparam logic [2:0] FS_LOAD   = 3'b010;  // full-width load
    localparam logic [2:0] FS_CLR    = 3'b011;  // clear
    localparam logic [2:0] FS_LDL_Z  = 3'b100;  // low half load, upper half zeroed
    localparam logic [2:0] FS_LDL_K  = 3'b101;  // low half load, upper half kept
    localparam logic [2:0] FS_LDH_K  = 3'b110;  // I low half into upper half, lower half kept
    localparam logic [2:0] FS_LDL_SX = 3'b111;  // low half load, sign-extended

endpackage

// File: rtl/register_cell.sv
// One register of the bank: applies FunSel when enabled and flags inc/dec
// boundary crossings (wrap or saturation) for the shared Wrap flop.
module register_cell
    import reg_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int SAT_MODE = 0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             E,
    input  logic [2:0]       FunSel,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] Q,
    output logic             boundary
);

    localparam int H = WIDTH / 2;

    logic [WIDTH-1:0] q_next;
    logic             at_edge;

    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        q_next  = Q;
        at_edge = 1'b0;
        case (FunSel)
            FS_DEC: begin
                at_edge = (Q == '0);
                q_next  = (at_edge && SAT_MODE != 0) ? Q : Q - WIDTH'(1);
            end
            FS_INC: begin
                at_edge = (&Q);
                q_next  = (at_edge && SAT_MODE != 0) ? Q : Q + WIDTH'(1);
            end
            FS_LOAD:   q_next = I;
            FS_CLR:    q_next = '0;
            FS_LDL_Z:  q_next = {{H{1'b0}}, I[H-1:0]};
            FS_LDL_K:  q_next = {Q[WIDTH-1:H], I[H-1:0]};
            FS_LDH_K:  q_next = {I[H-1:0], Q[H-1:0]};
            FS_LDL_SX: q_next = {{H{I[H-1]}}, I[H-1:0]};
            default:   q_next = Q;
        endcase
    end

    // A boundary only counts when this register is actually being written.
    assign boundary = E & at_edge;

    // NOTE: state is updated with non-blocking assignments so every cell
    // samples the pre-edge value of its neighbours and inputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Q <= '0;
        end else if (E) begin
            Q <= q_next;
        end
    end

endmodule

// File: rtl/register_bank.sv
// Parametrised register file: masked multi-register writes, two combinational
// read ports, ZeroA detect and a registered wrap/saturate event flag.
module register_bank
    import reg_pkg::*;
#(
    parameter int  WIDTH    = 16,
    parameter int  NUM_REGS = 4,
    parameter int  SAT_MODE = 0,
    localparam int SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [WIDTH-1:0]    I,
    input  logic [NUM_REGS-1:0] RegSel,
    input  logic [2:0]          FunSel,
    input  logic [SEL_W-1:0]    OutASel,
    input  logic [SEL_W-1:0]    OutBSel,
    output logic [WIDTH-1:0]    OutA,
    output logic [WIDTH-1:0]    OutB,
    output logic                ZeroA,
    output logic                Wrap
);

    logic [WIDTH-1:0]    q [NUM_REGS];
    logic [NUM_REGS-1:0] hit;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_cell
        register_cell #(
            .WIDTH    (WIDTH),
            .SAT_MODE (SAT_MODE)
        ) u_cell (
            .Clock    (Clock),
            .Reset    (Reset),
            .E        (RegSel[k]),
            .FunSel   (FunSel),
            .I        (I),
            .Q        (q[k]),
            .boundary (hit[k])
        );
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Wrap <= 1'b0;
        end else begin
            Wrap <= |hit;
        end
    end

    // Select decode by comparison: selects beyond NUM_REGS fall through to 0.
    always_comb begin
        OutA = '0;
        OutB = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (OutASel == SEL_W'(k)) OutA = q[k];
            if (OutBSel == SEL_W'(k)) OutB = q[k];
        end
    end

    assign ZeroA = (OutA == '0);

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench: one stimulus stream drives three bank variants (wrap,
// saturate, three registers) and a queue-based monitor checks their outputs.
module tb_register_bank;
    import reg_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] I     = '0;
    logic [3:0]  regsel = '0;
    logic [2:0]  FunSel = '0;
    logic [1:0]  OutASel = '0;
    logic [1:0]  OutBSel = '0;

    logic [15:0] out_a [3];
    logic [15:0] out_b [3];
    logic        zero_a [3];
    logic        wrap [3];

    always #5 Clock = ~Clock;

    register_bank #(.WIDTH(16), .NUM_REGS(4), .SAT_MODE(0)) dut0 (
        .Clock(Clock), .Reset(Reset), .I(I), .RegSel(regsel), .FunSel(FunSel),
        .OutASel(OutASel), .OutBSel(OutBSel),
        .OutA(out_a[0]), .OutB(out_b[0]), .ZeroA(zero_a[0]), .Wrap(wrap[0]));

    register_bank #(.WIDTH(16), .NUM_REGS(4), .SAT_MODE(1)) dut1 (
        .Clock(Clock), .Reset(Reset), .I(I), .RegSel(regsel), .FunSel(FunSel),
        .OutASel(OutASel), .OutBSel(OutBSel),
        .OutA(out_a[1]), .OutB(out_b[1]), .ZeroA(zero_a[1]), .Wrap(wrap[1]));

    register_bank #(.WIDTH(16), .NUM_REGS(3), .SAT_MODE(0)) dut2 (
        .Clock(Clock), .Reset(Reset), .I(I), .RegSel(regsel[2:0]), .FunSel(FunSel),
        .OutASel(OutASel), .OutBSel(OutBSel),
        .OutA(out_a[2]), .OutB(out_b[2]), .ZeroA(zero_a[2]), .Wrap(wrap[2]));

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        za;
        logic        wr;
    } obs_t;
    typedef obs_t [2:0] trio_t;

    trio_t sb[$];
    int    checks   = 0;
    int    failures = 0;
    bit    stim_done = 1'b0;

    // Reference model: plain arrays of register values per variant.
    logic [15:0] m_q [3][4];
    bit          m_wr [3];

    function automatic int nregs(int d);
        return (d == 2) ? 3 : 4;
    endfunction

    function automatic bit saturating(int d);
        return d == 1;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_read(int d, logic [1:0] sel);
        if (int'(sel) < nregs(d)) return m_q[d][sel];
        return 16'h0000;
    endfunction

    task automatic model_step(logic [3:0] rs, logic [2:0] fs, logic [15:0] data);
        int q, lo, nq;
        bit hit;
        for (int d = 0; d < 3; d++) begin
            hit = 1'b0;
            for (int k = 0; k < nregs(d); k++) begin
                if (rs[k]) begin
                    q  = int'(m_q[d][k]);
                    lo = int'(data) % 256;
                    nq = q;
                    case (fs)
                        FS_DEC:
                            if (q == 0) begin
                                hit = 1'b1;
                                nq  = saturating(d) ? 0 : 65535;
                            end else nq = q - 1;
                        FS_INC:
                            if (q == 65535) begin
                                hit = 1'b1;
                                nq  = saturating(d) ? 65535 : 0;
                            end else nq = q + 1;
                        FS_LOAD:   nq = int'(data);
                        FS_CLR:    nq = 0;
                        FS_LDL_Z:  nq = lo;
                        FS_LDL_K:  nq = (q / 256) * 256 + lo;
                        FS_LDH_K:  nq = lo * 256 + q % 256;
                        FS_LDL_SX: nq = (lo >= 128) ? 65280 + lo : lo;
                        default:   nq = q;
                    endcase
                    m_q[d][k] = 16'(nq);
                end
            end
            m_wr[d] = hit;
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue what every
    // variant must show before the next rising edge.
    task automatic drive(logic [3:0] rs, logic [2:0] fs, logic [15:0] data,
                         logic [1:0] asel, logic [1:0] bsel, logic rst);
        trio_t e;
        @(negedge Clock);
        regsel = rs; FunSel = fs; I = data;
        OutASel = asel; OutBSel = bsel; Reset = rst;
        if (rst) begin
            for (int d = 0; d < 3; d++) begin
                for (int k = 0; k < 4; k++) m_q[d][k] = 16'h0000;
                m_wr[d] = 1'b0;
            end
        end
        for (int d = 0; d < 3; d++) begin
            e[d].a  = model_read(d, asel);
            e[d].b  = model_read(d, bsel);
            e[d].za = (e[d].a == 16'h0000);
            e[d].wr = m_wr[d];
        end
        sb.push_back(e);
        if (!rst) model_step(rs, fs, data);
    endtask

    // Monitor: compares one queued expectation per cycle, mid low phase.
    initial begin
        trio_t e;
        forever begin
            @(negedge Clock);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int d = 0; d < 3; d++) begin
                    check($sformatf("dut%0d OutA", d),  32'(out_a[d]),  32'(e[d].a));
                    check($sformatf("dut%0d OutB", d),  32'(out_b[d]),  32'(e[d].b));
                    check($sformatf("dut%0d ZeroA", d), 32'(zero_a[d]), 32'(e[d].za));
                    check($sformatf("dut%0d Wrap", d),  32'(wrap[d]),   32'(e[d].wr));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Stimulus: directed scenarios first, then randomized traffic.
    initial begin
        logic [15:0] data;
        logic [2:0]  fs;
        // reset, load, then async reset between edges and held across one edge
        drive(4'b0000, FS_LOAD, 16'h0000,   2'd0, 2'd0, 1'b1);
        drive(4'b0001, FS_LOAD, 16'hBEEF,   2'd0, 2'd0, 1'b0);
        drive(4'b0000, FS_LOAD, 16'h0000,   2'd0, 2'd1, 1'b0);
        drive(4'b0001, FS_LOAD, 16'h1111,   2'd0, 2'd0, 1'b1);
        drive(4'b0000, FS_LOAD, 16'h0000,   2'd0, 2'd0, 1'b0);
        // multi-write and half-word loads
        drive(4'b0110, FS_LOAD,   16'h1234, 2'd1, 2'd2, 1'b0);
        drive(4'b0010, FS_LDL_K,  16'h00AB, 2'd0, 2'd3, 1'b0);
        drive(4'b0010, FS_LDH_K,  16'h00CD, 2'd1, 2'd2, 1'b0);
        drive(4'b0000, FS_LOAD,   16'h0000, 2'd1, 2'd0, 1'b0);
        // sign extension and zero-extended low load
        drive(4'b0001, FS_LDL_SX, 16'h0080, 2'd0, 2'd1, 1'b0);
        drive(4'b0001, FS_LDL_SX, 16'h007F, 2'd0, 2'd1, 1'b0);
        drive(4'b0001, FS_LDL_Z,  16'hFF80, 2'd0, 2'd1, 1'b0);
        drive(4'b0000, FS_LOAD,   16'h0000, 2'd0, 2'd1, 1'b0);
        // inc/dec boundaries on R3 (absent in the three-register variant)
        drive(4'b1000, FS_LOAD, 16'hFFFF,   2'd3, 2'd3, 1'b0);
        drive(4'b1000, FS_INC,  16'h0000,   2'd3, 2'd3, 1'b0);
        drive(4'b1000, FS_DEC,  16'h0000,   2'd3, 2'd3, 1'b0);
        drive(4'b1000, FS_LOAD, 16'h0005,   2'd3, 2'd3, 1'b0);
        drive(4'b1000, FS_INC,  16'h0000,   2'd3, 2'd3, 1'b0);
        drive(4'b0000, FS_INC,  16'h0000,   2'd3, 2'd0, 1'b0);
        // R0 saturation sequence, meaningful on every variant
        drive(4'b0001, FS_LOAD, 16'hFFFF,   2'd0, 2'd0, 1'b0);
        drive(4'b0001, FS_INC,  16'h0000,   2'd0, 2'd0, 1'b0);
        drive(4'b0001, FS_INC,  16'h0000,   2'd0, 2'd0, 1'b0);
        drive(4'b0001, FS_CLR,  16'h0000,   2'd0, 2'd0, 1'b0);
        drive(4'b0001, FS_DEC,  16'h0000,   2'd0, 2'd0, 1'b0);
        drive(4'b0000, FS_DEC,  16'h0000,   2'd0, 2'd0, 1'b0);
        // same select on both ports, write R2, out-of-range select
        drive(4'b0100, FS_LOAD, 16'h5A5A,   2'd2, 2'd2, 1'b0);
        drive(4'b0000, FS_LOAD, 16'h0000,   2'd2, 2'd2, 1'b0);
        drive(4'b0000, FS_LOAD, 16'h0000,   2'd3, 2'd2, 1'b0);
        // randomized traffic biased toward boundary values
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 4))
                0:       data = 16'hFFFF;
                1:       data = 16'h0000;
                2:       data = 16'h0080;
                default: data = 16'($urandom);
            endcase
            fs = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) fs = 3'($urandom_range(0, 1));
            drive(4'($urandom), fs, data, 2'($urandom), 2'($urandom),
                  ($urandom_range(0, 39) == 0));
        end
        stim_done = 1'b1;
    end

    initial begin
        wait (stim_done);
        repeat (3) @(negedge Clock);
        #3;
        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
Parametrised bank of NUM_REGS general-purpose registers, each WIDTH bits, for the datapath register file. Extends the single 16-bit inc/dec/load/clear register with several features:
- multi-register write mask
- 3-bit FunSel with half-word and sign-extending loads
- optional saturating arithmetic
- a registered wrap/saturate flag
- two combinational read ports

Parameters:
WIDTH, 16, register width in bits; must be even and >= 4
NUM_REGS, 4, number of registers; 2..16
SAT_MODE, 0, 0 = inc/dec wrap modulo 2^WIDTH; 1 = inc/dec saturate at all-ones / zero

Ports:
Clock  input  1  system clock; all state updates on posedge
Reset  input  1  asynchronous, active-high; clears all state immediately
I  input  WIDTH  load data
RegSel  input  NUM_REGS  write-enable mask; bit k enables register k; any subset allowed
FunSel  input  3  operation applied to every selected register
OutASel  input  clog2(NUM_REGS)  read port A select
OutBSel  input  clog2(NUM_REGS)  read port B select
OutA  output  WIDTH  contents of register OutASel
OutB  output  WIDTH  contents of register OutBSel
ZeroA  output  1  high when OutA == 0
Wrap  output  1  registered event flag (see below)

Behaviour:
- Reset high (async):
  - all registers = 0, Wrap = 0
  - OutA/OutB/ZeroA follow combinationally: 0, 0, 1
  - Reset asserted mid-operation discards any pending update; the first posedge after Reset deasserts performs a normal update.
- Per posedge, each register k with RegSel[k]=1 updates per FunSel (H = WIDTH/2, L = I[H-1:0]):
  - 000: Q <= Q - 1
  - 001: Q <= Q + 1
  - 010: Q <= I
  - 011: Q <= 0
  - 100: Q <= {zeros, L}
  - 101: Q <= {Q[WIDTH-1:H], L}  (upper half retained)
  - 110: Q <= {I[H-1:0], Q[H-1:0]}  (low half of I into upper half, lower half retained)
  - 111: Q <= sign-extended L  (replicate I[H-1] into the upper half)
- Registers with RegSel[k]=0 hold. RegSel = 0 is a no-op.
- Inc/dec boundaries:
  - SAT_MODE=0: all-ones + 1 -> 0; 0 - 1 -> all-ones.
  - SAT_MODE=1: all-ones + 1 -> all-ones; 0 - 1 -> 0.
- Wrap:
  - Registered; asserted in the cycle after any posedge where at least one selected register hit an inc/dec boundary (OR across registers).
  - Otherwise 0 on that posedge; it is a one-cycle pulse unless the boundary repeats.
  - In SAT_MODE=1 it means "saturation occurred".
- Read ports:
  - Purely combinational from current register state; zero-latency read.
  - A write becomes visible on OutA/OutB the cycle after the posedge; no write-through bypass.
  - OutASel == OutBSel is legal.
  - A select >= NUM_REGS drives 0 on that port; ZeroA is then 1.
- Simultaneous events: reading a register while writing it returns the old value until the edge. Multiple selected registers update independently from their own Q with a shared I.
- Widths: all arithmetic is unsigned modulo 2^WIDTH before the saturation override; no carry-out port.

Decomposition:
- Shared package (reg_pkg): FunSel encodings FS_DEC, FS_INC, FS_LOAD, FS_CLR, FS_LDL_Z, FS_LDL_K, FS_LDH_K, FS_LDL_SX (3-bit localparams).
- One sub-module, register_cell:
  - parameters WIDTH, SAT_MODE
  - ports Clock, Reset, E, FunSel, I, Q, boundary
  - generated NUM_REGS times
- Read muxes, ZeroA and the Wrap flop live in register_bank.

Test Plan:
1. Reset: load 0xBEEF into R0 (RegSel=0001, FunSel=010), then assert Reset between edges -> OutA (sel 0) = 0x0000 immediately, ZeroA=1, Wrap=0, with no clock edge.
2. Multi-write with half-loads:
   - RegSel=0110, FunSel=010, I=0x1234 -> R1=R2=0x1234, R0 and R3 unchanged.
   - Then RegSel=0010, FunSel=101, I=0x00AB -> R1=0x12AB.
   - Then FunSel=110, I=0x00CD -> R1=0xCDAB.
3. Sign extension: FunSel=111, I=0x0080 -> 0xFF80; I=0x007F -> 0x007F. FunSel=100, I=0xFF80 -> 0x0080.
4. Wrap, SAT_MODE=0:
   - R3=0xFFFF, FunSel=001 -> R3=0x0000 and Wrap=1 for exactly one cycle.
   - Next FunSel=000 -> R3=0xFFFF and Wrap=1 again.
   - Then increment 0x0005 -> Wrap=0.
5. Saturate, SAT_MODE=1: R0=0xFFFF, increment twice -> stays 0xFFFF, Wrap=1 both cycles. R0=0, decrement -> 0, Wrap=1.
6. Read ports with NUM_REGS=3:
   - OutASel=OutBSel=2 -> both show R2.
   - OutASel=3 -> OutA=0, ZeroA=1.
   - Write R2 -> OutB changes only after the posedge.
